// File: rtl/head_prune_mean.sv
// head_prune_mean: sums DIM*NUM_MAT row beats, floors the mean and flags it when below a sampled threshold.
// Build option: define PRUNE_ABS_MEAN_EN to accumulate element magnitudes instead of signed values.
module head_prune_mean #(
    parameter int WIDTH   = 8,
    parameter int DIM     = 4,
    parameter int NUM_MAT = 2
) (
    input  logic                       clk,
    input  logic                       _reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DIM*2*WIDTH-1:0]     in_data,
    input  logic signed [2*WIDTH-1:0]  threshold,
    output logic                       result_valid,
    output logic                       prune_head,
    output logic signed [2*WIDTH-1:0]  mean_out
);
    // state   | meaning
    // IDLE    | waiting for the first row of a pass
    // ACCUM   | summing the remaining rows
    // COMPARE | forming the mean and the prune decision
    // DONE    | decision registered, pulse result_valid next edge

    localparam int EW    = 2 * WIDTH;
    localparam int SHIFT = $clog2(DIM * DIM * NUM_MAT);
    localparam int ACC_W = EW + SHIFT + 1;
    localparam int ROWS  = DIM * NUM_MAT;
    localparam int CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(ROWS - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, COMPARE, DONE} state_t;

    state_t                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic signed [EW-1:0]     thr_q, thr_d;
    logic signed [EW-1:0]     mean_q, mean_d;
    logic                     prune_q, prune_d;
    logic                     rv_q, rv_d;
    logic signed [ACC_W-1:0]  row_sum;
    logic                     accept;

    function automatic logic signed [ACC_W-1:0] widen(input logic signed [EW-1:0] e);
        logic signed [ACC_W-1:0] w;
        w = {{(ACC_W-EW){e[EW-1]}}, e};
`ifdef PRUNE_ABS_MEAN_EN
        // the extra accumulator bits absorb the magnitude of the most negative element
        if (w < 0) w = -w;
`endif
        return w;
    endfunction

    always_comb begin
        row_sum = '0;
        for (int c = 0; c < DIM; c++) begin
            row_sum = row_sum + widen(in_data[c*EW +: EW]);
        end
    end

    assign in_ready = (state_q == IDLE) || (state_q == ACCUM);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        thr_d   = thr_q;
        mean_d  = mean_q;
        prune_d = prune_q;
        rv_d    = (state_q == DONE);
        case (state_q)
            IDLE: begin
                if (accept) begin
                    acc_d = row_sum;
                    thr_d = threshold;
                    if (cnt_q == LAST_ROW) begin
                        cnt_d   = '0;
                        state_d = COMPARE;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_d = acc_q + row_sum;
                    if (cnt_q == LAST_ROW) begin
                        cnt_d   = '0;
                        state_d = COMPARE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            COMPARE: begin
                mean_d  = EW'(acc_q >>> SHIFT);
                prune_d = (EW'(acc_q >>> SHIFT) < thr_q);
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (_reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            thr_q   <= '0;
            mean_q  <= '0;
            prune_q <= 1'b0;
            rv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            thr_q   <= thr_d;
            mean_q  <= mean_d;
            prune_q <= prune_d;
            rv_q    <= rv_d;
        end
    end

    assign result_valid = rv_q;
    assign prune_head   = prune_q;
    assign mean_out     = mean_q;
endmodule

// File: doc/head_prune_mean.md
HEAD_PRUNE_MEAN -- requirements
Module: head_prune_mean

Interface
REQ-001 SHALL have parameter WIDTH, default 8; element operand width, so input elements are 2*WIDTH-bit signed products.
REQ-002 SHALL have parameter DIM, default 4; matrix dimension (rows per matrix, elements per row), power of two.
REQ-003 SHALL have parameter NUM_MAT, default 2; matrices accumulated per decision, power of two.
REQ-004 SHALL have port clk, input, 1 bit; single clock, all logic on rising edge.
REQ-005 SHALL have port _reset, input, 1 bit; reset is synchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1 bit; a row beat is present.
REQ-007 SHALL have port in_ready, output, 1 bit; block accepts a beat this cycle.
REQ-008 SHALL have port in_data, input, DIM*2*WIDTH bits; one row, element c at bits [c*2W +: 2W], signed.
REQ-009 SHALL have port threshold, input, 2*WIDTH bits, signed; prune threshold.
REQ-010 SHALL have port result_valid, output, 1 bit; one-cycle pulse when a decision is ready.
REQ-011 SHALL have port prune_head, output, 1 bit; decision, held until the next decision.
REQ-012 SHALL have port mean_out, output, 2*WIDTH bits, signed; computed mean, held with prune_head.

Function
REQ-013 SHALL implement states IDLE, ACCUM, COMPARE and DONE.
REQ-014 SHALL drive in_ready=1 in IDLE and ACCUM, and 0 in COMPARE and DONE.
REQ-015 SHALL accept a beat only when in_valid && in_ready; in_valid gaps neither advance the count nor change the sum.
REQ-016 SHALL clear the accumulator, load the first row sum and sample threshold into an internal register when IDLE accepts a beat, then move to ACCUM.
REQ-017 SHALL add each accepted row's element sum to the accumulator and increment the row counter in ACCUM.
REQ-018 SHALL size the accumulator at 2*WIDTH + log2(DIM*DIM*NUM_MAT) + 1 bits, sign-extend every element, and never overflow.
REQ-019 SHALL move to COMPARE when the accepted beat is row DIM*NUM_MAT-1 (zero-based); the counter wraps to 0.
REQ-020 SHALL, in COMPARE, compute mean = accumulator arithmetically right-shifted by log2(DIM*DIM*NUM_MAT) (floor toward minus infinity), truncate it to 2*WIDTH bits, and register mean_out.
REQ-021 SHALL, in COMPARE, set prune_head=1 iff mean < sampled threshold (signed, strict), else 0.
REQ-022 SHALL, in DONE, assert result_valid for exactly one cycle and then return to IDLE.
REQ-023 SHALL assert result_valid on the second rising edge after the edge that accepts the final beat.
REQ-024 SHALL ignore threshold changes during a pass; only the value sampled at the first beat is used.
REQ-025 SHALL ignore in_valid during COMPARE and DONE; the upstream holds the beat.
REQ-026 SHALL accept the next pass's first beat in the cycle after DONE, with no dead cycles beyond COMPARE and DONE.

Reset
REQ-027 SHALL, with _reset=1 at a rising edge, force IDLE, accumulator=0, row counter=0, result_valid=0, prune_head=0 and mean_out=0; in_ready then reads 1.
REQ-028 SHALL, on reset mid-pass, discard the partial pass entirely with no result_valid, and begin the next pass from row 0.
REQ-029 SHALL give _reset priority over a simultaneously accepted beat, which is discarded.

Configuration
REQ-030 SHALL, with macro PRUNE_ABS_MEAN_EN defined, accumulate the absolute value of each element; the most negative value maps to +2^(2W-1), widened by one bit before summing.
REQ-031 SHALL, without PRUNE_ABS_MEAN_EN, accumulate signed element values unchanged.

Verification (WIDTH=8, DIM=4, NUM_MAT=2: 8 beats, 32 elements, shift 5)
REQ-032 SHALL cover: 8 beats of all elements 50, threshold 60 -> mean_out=50, prune_head=1, result_valid 2 edges after beat 8.
REQ-033 SHALL cover: all 50, threshold 50 -> mean_out=50, prune_head=0 (strict compare).
REQ-034 SHALL cover: all -10, threshold 5 -> with PRUNE_ABS_MEAN_EN mean_out=10, prune_head=0; without it mean_out=-10, prune_head=1.
REQ-035 SHALL cover: 3 beats, _reset pulse, then 8 beats of 100, threshold 0 -> single result_valid, mean_out=100, prune_head=0.
REQ-036 SHALL cover: in_valid toggled every other cycle with threshold changed after beat 1 -> result identical to gap-free run using the first threshold.
REQ-037 SHALL cover: 31 elements 0 and one element 31, threshold 1 -> sum=31, mean_out=0 (floor), prune_head=1.
